// File: rtl/controle_multiciclo.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute,
// drives every datapath select and enable, and traps on illegal opcodes or
// memory accesses that stall for too long.
module controle_multiciclo #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TMO_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemToReg,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ZeroExt,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_EXEC_I    = 4'd11,
        S_I_WB      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_FN  = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
    localparam bit               TMO_EN    = (MEM_TIMEOUT != 0);

    state_t           cur;
    logic [TMO_W-1:0] tmo_cnt;
    logic             mem_state;
    logic             mem_wait;
    logic             tmo_hit;

    // Memory-stall detection: waiting in a memory state, and whether the stall budget is spent
    always_comb begin
        mem_state = (cur == S_FETCH) || (cur == S_MEM_READ) || (cur == S_MEM_WRITE);
        mem_wait  = mem_state && !mem_ready;
        tmo_hit   = TMO_EN && mem_wait && (tmo_cnt == TMO_LIMIT);
    end

    // State sequencing and stall counter; counter restarts on every state change or completed access
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur     <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            if (mem_wait && !tmo_hit) begin
                if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            case (cur)
                S_IDLE:     cur <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)    cur <= S_DECODE;
                    else if (tmo_hit) cur <= S_TRAP;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE: cur <= (funct == FN_JR) ? S_JR : S_EXEC_R;
                        OP_LW, OP_SW:   cur <= S_MEM_ADDR;
                        OP_BEQ, OP_BNE: cur <= S_BRANCH;
                        OP_J:     cur <= S_JUMP;
                        OP_JAL:   cur <= S_JAL;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: cur <= S_EXEC_I;
                        default:  cur <= S_TRAP;
                    endcase
                end
                S_MEM_ADDR: cur <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: begin
                    if (mem_ready)    cur <= S_MEM_WB;
                    else if (tmo_hit) cur <= S_TRAP;
                end
                S_MEM_WRITE: begin
                    if (mem_ready)    cur <= S_FETCH;
                    else if (tmo_hit) cur <= S_TRAP;
                end
                S_EXEC_R:   cur <= S_R_WB;
                S_EXEC_I:   cur <= S_I_WB;
                S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: cur <= S_FETCH;
                S_TRAP:     cur <= S_TRAP;
                default:    cur <= S_TRAP;
            endcase
        end
    end

    // Moore output decode from the state register and the IR fields; mem_ready only gates
    // the fetch write enables and the store completion pulse
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 2'b00;
        RegDst      = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ZeroExt     = 1'b0;
        ALUOp       = ALU_ADD;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        trap        = 1'b0;
        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FN;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = (opcode == OP_BNE);
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = 1'b1;
                RegDst     = 2'b10;
                MemToReg   = 2'b10;
                instr_done = 1'b1;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ZeroExt = (opcode == OP_ANDI) || (opcode == OP_ORI);
                case (opcode)
                    OP_ANDI: ALUOp = ALU_AND;
                    OP_ORI:  ALUOp = ALU_OR;
                    OP_SLTI: ALUOp = ALU_SLT;
                    default: ALUOp = ALU_ADD;
                endcase
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                ZeroExt    = (opcode == OP_ANDI) || (opcode == OP_ORI);
                instr_done = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    // Debug view of the current state
    always_comb state = 4'(cur);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: per-cycle vector table plus hand-written
// reset-abort and memory-timeout sequences.
module tb_controle_multiciclo;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemToReg, RegDst, ALUSrcB, PCSource;
    logic       RegWrite, ALUSrcA, ZeroExt, instr_done, trap;
    logic [3:0] ALUOp;
    logic [3:0] state;

    int checks;
    int failures;

    controle_multiciclo #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ZeroExt(ZeroExt), .ALUOp(ALUOp), .PCSource(PCSource), .instr_done(instr_done),
        .trap(trap), .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic [3:0]  st;
        logic [23:0] ex;
    } vec_t;

    vec_t vecs[$];

    // Expected output bundle, fields in the same order as the actual bundle below
    function automatic logic [23:0] o(input logic pcw, input logic pcwc, input logic bne,
                                      input logic iord, input logic mrd, input logic mwr,
                                      input logic irw, input logic [1:0] m2r, input logic [1:0] rdst,
                                      input logic rw, input logic asa, input logic [1:0] asb,
                                      input logic zx, input logic [3:0] aop, input logic [1:0] psrc,
                                      input logic done, input logic trp);
        return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, zx, aop, psrc, done, trp};
    endfunction

    function automatic logic [23:0] actual();
        return {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ZeroExt, ALUOp, PCSource, instr_done, trap};
    endfunction

    logic [23:0] P_IDLE, P_FETCH, P_FWAIT, P_DEC, P_MADDR, P_MRD, P_MWB, P_MWR0, P_MWR1;
    logic [23:0] P_EXR, P_RWB, P_BEQ, P_BNE, P_J, P_JAL, P_JR, P_TRAP;

    task automatic compare(input string nm, input logic [3:0] st, input logic [23:0] ex);
        checks++;
        if (state !== st || actual() !== ex) begin
            failures++;
            $display("FAIL %s: state got %0d exp %0d, outputs got %h exp %h", nm, state, st, actual(), ex);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, advance to the next falling edge
    task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic mr,
                        input logic [3:0] st, input logic [23:0] ex);
        opcode = op;
        funct = fn;
        mem_ready = mr;
        #1;
        compare(nm, st, ex);
        @(negedge clock);
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                       input logic [3:0] st, input logic [23:0] ex);
        vec_t v;
        v.op = op; v.fn = fn; v.mr = mr; v.st = st; v.ex = ex;
        vecs.push_back(v);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        opcode = 6'h00;
        funct = 6'h00;
        mem_ready = 1'b0;

        P_IDLE  = '0;
        P_FETCH = o(1,0,0,0,1,0,1,2'd0,2'd0,0,0,2'd1,0,4'd0,2'd0,0,0);
        P_FWAIT = o(0,0,0,0,1,0,0,2'd0,2'd0,0,0,2'd1,0,4'd0,2'd0,0,0);
        P_DEC   = o(0,0,0,0,0,0,0,2'd0,2'd0,0,0,2'd3,0,4'd0,2'd0,0,0);
        P_MADDR = o(0,0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,0,4'd0,2'd0,0,0);
        P_MRD   = o(0,0,0,1,1,0,0,2'd0,2'd0,0,0,2'd0,0,4'd0,2'd0,0,0);
        P_MWB   = o(0,0,0,0,0,0,0,2'd1,2'd0,1,0,2'd0,0,4'd0,2'd0,1,0);
        P_MWR0  = o(0,0,0,1,0,1,0,2'd0,2'd0,0,0,2'd0,0,4'd0,2'd0,0,0);
        P_MWR1  = o(0,0,0,1,0,1,0,2'd0,2'd0,0,0,2'd0,0,4'd0,2'd0,1,0);
        P_EXR   = o(0,0,0,0,0,0,0,2'd0,2'd0,0,1,2'd0,0,4'd2,2'd0,0,0);
        P_RWB   = o(0,0,0,0,0,0,0,2'd0,2'd1,1,0,2'd0,0,4'd0,2'd0,1,0);
        P_BEQ   = o(0,1,0,0,0,0,0,2'd0,2'd0,0,1,2'd0,0,4'd1,2'd1,1,0);
        P_BNE   = o(0,1,1,0,0,0,0,2'd0,2'd0,0,1,2'd0,0,4'd1,2'd1,1,0);
        P_J     = o(1,0,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,0,4'd0,2'd2,1,0);
        P_JAL   = o(1,0,0,0,0,0,0,2'd2,2'd2,1,0,2'd0,0,4'd0,2'd2,1,0);
        P_JR    = o(1,0,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,0,4'd0,2'd3,1,0);
        P_TRAP  = o(0,0,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,0,4'd0,2'd0,0,1);

        // add (R-type): 1,2,7,8
        add(6'h00, 6'h20, 1, 4'd0,  P_IDLE);
        add(6'h00, 6'h20, 1, 4'd1,  P_FETCH);
        add(6'h00, 6'h20, 1, 4'd2,  P_DEC);
        add(6'h00, 6'h20, 1, 4'd7,  P_EXR);
        add(6'h00, 6'h20, 1, 4'd8,  P_RWB);
        // lw with three stall cycles in MEM_READ
        add(6'h23, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h23, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h23, 6'h00, 1, 4'd3,  P_MADDR);
        add(6'h23, 6'h00, 0, 4'd4,  P_MRD);
        add(6'h23, 6'h00, 0, 4'd4,  P_MRD);
        add(6'h23, 6'h00, 0, 4'd4,  P_MRD);
        add(6'h23, 6'h00, 1, 4'd4,  P_MRD);
        add(6'h23, 6'h00, 1, 4'd5,  P_MWB);
        // sw with a fetch stall and a write stall
        add(6'h2B, 6'h00, 0, 4'd1,  P_FWAIT);
        add(6'h2B, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h2B, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h2B, 6'h00, 1, 4'd3,  P_MADDR);
        add(6'h2B, 6'h00, 0, 4'd6,  P_MWR0);
        add(6'h2B, 6'h00, 1, 4'd6,  P_MWR1);
        // beq, bne, j, jal, jr
        add(6'h04, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h04, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h04, 6'h00, 1, 4'd9,  P_BEQ);
        add(6'h05, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h05, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h05, 6'h00, 1, 4'd9,  P_BNE);
        add(6'h02, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h02, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h02, 6'h00, 1, 4'd10, P_J);
        add(6'h03, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h03, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h03, 6'h00, 1, 4'd13, P_JAL);
        add(6'h00, 6'h08, 1, 4'd1,  P_FETCH);
        add(6'h00, 6'h08, 1, 4'd2,  P_DEC);
        add(6'h00, 6'h08, 1, 4'd14, P_JR);
        // immediates: andi, ori, slti, addi
        add(6'h0C, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h0C, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h0C, 6'h00, 1, 4'd11, o(0,0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,1,4'd3,2'd0,0,0));
        add(6'h0C, 6'h00, 1, 4'd12, o(0,0,0,0,0,0,0,2'd0,2'd0,1,0,2'd0,1,4'd0,2'd0,1,0));
        add(6'h0D, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h0D, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h0D, 6'h00, 1, 4'd11, o(0,0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,1,4'd4,2'd0,0,0));
        add(6'h0D, 6'h00, 1, 4'd12, o(0,0,0,0,0,0,0,2'd0,2'd0,1,0,2'd0,1,4'd0,2'd0,1,0));
        add(6'h0A, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h0A, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h0A, 6'h00, 1, 4'd11, o(0,0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,0,4'd5,2'd0,0,0));
        add(6'h0A, 6'h00, 1, 4'd12, o(0,0,0,0,0,0,0,2'd0,2'd0,1,0,2'd0,0,4'd0,2'd0,1,0));
        add(6'h08, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h08, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h08, 6'h00, 1, 4'd11, o(0,0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,0,4'd0,2'd0,0,0));
        add(6'h08, 6'h00, 1, 4'd12, o(0,0,0,0,0,0,0,2'd0,2'd0,1,0,2'd0,0,4'd0,2'd0,1,0));
        // illegal opcode traps and stays trapped
        add(6'h3F, 6'h00, 1, 4'd1,  P_FETCH);
        add(6'h3F, 6'h00, 1, 4'd2,  P_DEC);
        add(6'h3F, 6'h00, 1, 4'd15, P_TRAP);
        add(6'h00, 6'h20, 0, 4'd15, P_TRAP);
        add(6'h00, 6'h20, 1, 4'd15, P_TRAP);

        // Reset state
        @(negedge clock);
        @(negedge clock);
        #1;
        compare("reset", 4'd0, P_IDLE);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].mr, vecs[i].st, vecs[i].ex);

        // Reset asserted during EXEC_R aborts at once; FETCH one cycle after release
        pulse_reset();
        step("rst_idle",  6'h00, 6'h20, 1, 4'd0, P_IDLE);
        step("rst_fetch", 6'h00, 6'h20, 1, 4'd1, P_FETCH);
        step("rst_dec",   6'h00, 6'h20, 1, 4'd2, P_DEC);
        opcode = 6'h00;
        funct = 6'h20;
        #1;
        compare("rst_exec", 4'd7, P_EXR);
        reset = 1'b1;
        #1;
        compare("rst_async", 4'd0, P_IDLE);
        @(negedge clock);
        #1;
        compare("rst_hold", 4'd0, P_IDLE);
        reset = 1'b0;
        step("rst_rel_idle",  6'h00, 6'h20, 1, 4'd0, P_IDLE);
        step("rst_rel_fetch", 6'h00, 6'h20, 1, 4'd1, P_FETCH);

        // mem_ready stuck low in FETCH: counter runs 0..4, trap on the cycle it reaches 4
        pulse_reset();
        step("tmo_idle", 6'h00, 6'h20, 0, 4'd0, P_IDLE);
        for (int k = 0; k < 5; k++)
            step($sformatf("tmo_wait%0d", k), 6'h00, 6'h20, 0, 4'd1, P_FWAIT);
        step("tmo_trap0", 6'h00, 6'h20, 0, 4'd15, P_TRAP);
        step("tmo_trap1", 6'h00, 6'h20, 1, 4'd15, P_TRAP);

        // mem_ready arriving on the timeout cycle wins; counter restarts in MEM_READ
        pulse_reset();
        step("race_idle", 6'h23, 6'h00, 0, 4'd0, P_IDLE);
        for (int k = 0; k < 4; k++)
            step($sformatf("race_fwait%0d", k), 6'h23, 6'h00, 0, 4'd1, P_FWAIT);
        step("race_fetch", 6'h23, 6'h00, 1, 4'd1, P_FETCH);
        step("race_dec",   6'h23, 6'h00, 1, 4'd2, P_DEC);
        step("race_maddr", 6'h23, 6'h00, 1, 4'd3, P_MADDR);
        for (int k = 0; k < 4; k++)
            step($sformatf("race_rwait%0d", k), 6'h23, 6'h00, 0, 4'd4, P_MRD);
        step("race_rdy",   6'h23, 6'h00, 1, 4'd4, P_MRD);
        step("race_wb",    6'h23, 6'h00, 1, 4'd5, P_MWB);
        step("race_next",  6'h23, 6'h00, 1, 4'd1, P_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
